// File: rtl/spi_slave_mem_sequencer.sv
// Turns SPI address/data streams into auto-incrementing req/gnt word accesses; writes cost 2 cycles/word.
// Reads prefetch into TX under credit (tx_space, MAX_OUTSTANDING); abort stops issue and drains the bus.
module spi_slave_mem_sequencer #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int SPACE_WIDTH     = 4
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  input  logic                   abort,
  input  logic [ADDR_WIDTH-1:0]  rx_addr,
  input  logic                   rx_rd_wr,
  input  logic                   rx_addr_valid,
  output logic                   rx_addr_ready,
  input  logic [31:0]            rx_data,
  input  logic                   rx_data_valid,
  output logic                   rx_data_ready,
  output logic [31:0]            tx_data,
  output logic                   tx_data_valid,
  input  logic [SPACE_WIDTH-1:0] tx_space,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_be,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [31:0]            mem_rdata,
  input  logic                   mem_err,
  output logic                   busy,
  output logic                   err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam int          OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] MAX_OUT = MAX_OUTSTANDING;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [OUT_W-1:0]      outstanding;
  logic [31:0]           outs_ext;
  logic [31:0]           space_ext;
  logic                  pending_req;
  logic                  gnt_hit;
  logic                  rd_gnt;
  logic                  rd_ret;
  logic                  wr_acc;
  logic                  rd_issue;
  logic                  idle_ok;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^rx_addr[1:0];

  assign outs_ext    = 32'(outstanding);
  assign space_ext   = 32'(tx_space);
  assign pending_req = mem_req && !mem_we;
  assign gnt_hit     = mem_req && mem_gnt;
  assign rd_gnt      = gnt_hit && !mem_we;
  // Write responses arrive with outstanding==0 and are never counted as read returns.
  assign rd_ret      = mem_rvalid && (outstanding != '0);
  assign idle_ok     = !mem_req && (outstanding == '0);

  assign rx_addr_ready = (state == IDLE) && !abort;
  assign rx_data_ready = (state == WRITE) && !mem_req && !abort;
  assign wr_acc        = rx_data_valid && rx_data_ready;
  assign rd_issue      = (state == READ) && !abort && !mem_req
                         && ((outs_ext + 32'd1 + {31'd0, pending_req}) <= MAX_OUT)
                         && (outs_ext < space_ext);

  assign tx_data_valid = (state == READ) && rd_ret;
  assign tx_data       = tx_data_valid ? mem_rdata : 32'd0;
  assign mem_be        = 4'hF;
  assign busy          = (state != IDLE);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state <= IDLE;
      addr  <= '0;
    end else begin
      if (gnt_hit) addr <= addr + ADDR_WIDTH'(4);
      case (state)
        IDLE: begin
          if (rx_addr_valid && rx_addr_ready) begin
            addr  <= {rx_addr[ADDR_WIDTH-1:2], 2'b00};
            state <= rx_rd_wr ? READ : WRITE;
          end
        end
        WRITE, READ: begin
          if (abort) state <= idle_ok ? IDLE : DRAIN;
        end
        DRAIN: begin
          if (idle_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A request, once raised, is frozen until granted; issue is gated on !mem_req.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (gnt_hit) begin
      mem_req <= 1'b0;
    end else if (wr_acc) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b1;
      mem_addr  <= addr;
      mem_wdata <= rx_data;
    end else if (rd_issue) begin
      mem_req  <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= addr;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      case ({rd_gnt, rd_ret})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (mem_rvalid && mem_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_slave_mem_sequencer.sv
// Directed bench for spi_slave_mem_sequencer with a latency-programmable req/gnt bus responder.
module tb_spi_slave_mem_sequencer;

  logic        axi_aclk = 1'b0;
  logic        axi_aresetn;
  logic        abort;
  logic [31:0] rx_addr;
  logic        rx_rd_wr;
  logic        rx_addr_valid;
  logic        rx_addr_ready;
  logic [31:0] rx_data;
  logic        rx_data_valid;
  logic        rx_data_ready;
  logic [31:0] tx_data;
  logic        tx_data_valid;
  logic [3:0]  tx_space;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        busy;
  logic        err;

  always #5 axi_aclk = ~axi_aclk;

  spi_slave_mem_sequencer dut (
    .axi_aclk      (axi_aclk),
    .axi_aresetn   (axi_aresetn),
    .abort         (abort),
    .rx_addr       (rx_addr),
    .rx_rd_wr      (rx_rd_wr),
    .rx_addr_valid (rx_addr_valid),
    .rx_addr_ready (rx_addr_ready),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_space      (tx_space),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .mem_err       (mem_err),
    .busy          (busy),
    .err           (err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } gnt_t;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        we;
  } rsp_t;

  int total = 0;
  int bad   = 0;

  gnt_t        glog[$];
  rsp_t        rq[$];
  logic [31:0] tx_log[$];

  // Bus responder knobs, changed only on the falling edge.
  logic gnt_en   = 1'b1;
  int   rlat     = 2;
  int   err_idx  = -1;
  int   resp_idx = 0;
  int   outs_cnt = 0;
  int   max_outs = 0;
  int   cyc      = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Read data is the address with a fixed marker in the upper half.
  initial begin
    logic prev_rd_gnt;
    logic prev_rd_ret;
    rsp_t r;
    prev_rd_gnt = 1'b0;
    prev_rd_ret = 1'b0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'd0;
    mem_err     = 1'b0;
    forever begin
      @(posedge axi_aclk);
      #1;
      cyc++;
      if (!axi_aresetn) begin
        rq.delete();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; mem_err = 1'b0;
        outs_cnt = 0; prev_rd_gnt = 1'b0; prev_rd_ret = 1'b0;
        continue;
      end
      if (prev_rd_gnt) outs_cnt++;
      if (prev_rd_ret) outs_cnt--;
      if (outs_cnt > max_outs) max_outs = outs_cnt;
      mem_gnt     = gnt_en && mem_req;
      prev_rd_gnt = mem_gnt && !mem_we;
      if (mem_gnt) begin
        glog.push_back('{mem_we, mem_addr, mem_wdata, mem_be});
        rq.push_back('{cyc + rlat, mem_we ? 32'd0 : (mem_addr ^ 32'h5A5A_0000), mem_we});
      end
      mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = 32'd0; prev_rd_ret = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        resp_idx++;
        mem_rvalid  = 1'b1;
        mem_rdata   = r.data;
        mem_err     = (resp_idx == err_idx);
        prev_rd_ret = !r.we;
      end
    end
  end

  initial begin
    forever begin
      @(negedge axi_aclk);
      if (tx_data_valid) tx_log.push_back(tx_data);
    end
  end

  task automatic send_cmd(input logic [31:0] a, input logic rw);
    logic rdy;
    @(posedge axi_aclk); #1;
    rx_addr = a; rx_rd_wr = rw; rx_addr_valid = 1'b1;
    @(negedge axi_aclk);
    rdy = rx_addr_ready;
    @(posedge axi_aclk); #1;
    rx_addr_valid = 1'b0;
    chk("cmd_rdy", 64'(rdy), 64'd1);
  endtask

  task automatic send_word(input logic [31:0] d);
    logic done;
    done = 1'b0;
    @(posedge axi_aclk); #1;
    rx_data = d; rx_data_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge axi_aclk);
      done = rx_data_ready;
      @(posedge axi_aclk); #1;
    end
    rx_data_valid = 1'b0;
    chk("wr_accept", 64'(done), 64'd1);
  endtask

  task automatic do_abort;
    @(posedge axi_aclk); #1 abort = 1'b1;
    @(posedge axi_aclk); #1 abort = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge axi_aclk);
      n++;
    end while (busy && n < 60);
    chk(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx_base;
    int n;
    axi_aresetn = 1'b0; abort = 1'b0;
    rx_addr = 32'd0; rx_rd_wr = 1'b0; rx_addr_valid = 1'b0;
    rx_data = 32'd0; rx_data_valid = 1'b0; tx_space = 4'd8;

    repeat (3) @(negedge axi_aclk);
    chk("rst_addr_rdy", 64'(rx_addr_ready), 64'd1);
    chk("rst_busy",     64'(busy),          64'd0);
    chk("rst_req",      64'(mem_req),       64'd0);
    chk("rst_be",       64'(mem_be),        64'hF);
    chk("rst_err",      64'(err),           64'd0);
    chk("rst_txv",      64'(tx_data_valid), 64'd0);
    chk("rst_data_rdy", 64'(rx_data_ready), 64'd0);
    axi_aresetn = 1'b1;

    // Write burst, unaligned start address, grant tied high.
    glog.delete();
    send_cmd(32'h0000_1003, 1'b0);
    send_word(32'hAAAA_0001);
    send_word(32'hBBBB_0002);
    send_word(32'hCCCC_0003);
    repeat (4) @(negedge axi_aclk);
    chk("wr_busy", 64'(busy), 64'd1);
    do_abort();
    wait_idle("wr_idle");
    chk("wr_count", 64'(glog.size()), 64'd3);
    chk("wr0_addr", 64'(glog[0].addr),  64'h1000);
    chk("wr0_data", 64'(glog[0].wdata), 64'hAAAA_0001);
    chk("wr1_addr", 64'(glog[1].addr),  64'h1004);
    chk("wr1_data", 64'(glog[1].wdata), 64'hBBBB_0002);
    chk("wr2_addr", 64'(glog[2].addr),  64'h1008);
    chk("wr2_data", 64'(glog[2].wdata), 64'hCCCC_0003);
    chk("wr2_we",   64'(glog[2].we),    64'd1);
    chk("wr_be",    64'(glog[1].be),    64'hF);

    // Read prefetch with short latency.
    glog.delete(); tx_base = tx_log.size(); max_outs = 0; rlat = 2; tx_space = 4'd8;
    send_cmd(32'h0000_2000, 1'b1);
    repeat (20) @(negedge axi_aclk);
    chk("rd_outs_le2", 64'(max_outs <= 2), 64'd1);
    chk("rd0_addr", 64'(glog[0].addr), 64'h2000);
    chk("rd1_addr", 64'(glog[1].addr), 64'h2004);
    chk("rd3_addr", 64'(glog[3].addr), 64'h200C);
    chk("rd1_we",   64'(glog[1].we),   64'd0);
    chk("tx0", 64'(tx_log[tx_base + 0]), 64'h5A5A_2000);
    chk("tx1", 64'(tx_log[tx_base + 1]), 64'h5A5A_2004);
    chk("tx2", 64'(tx_log[tx_base + 2]), 64'h5A5A_2008);
    chk("tx3", 64'(tx_log[tx_base + 3]), 64'h5A5A_200C);
    do_abort();
    wait_idle("rd_idle");

    // Long latency: the outstanding cap is reached but never exceeded.
    max_outs = 0; rlat = 5;
    send_cmd(32'h0000_2100, 1'b1);
    repeat (20) @(negedge axi_aclk);
    chk("cap_max_outs", 64'(max_outs), 64'd2);
    do_abort();
    wait_idle("cap_idle");

    // Credit stall: one free TX entry allows exactly one read in flight.
    glog.delete(); max_outs = 0; rlat = 6; tx_space = 4'd1;
    send_cmd(32'h0000_3000, 1'b1);
    repeat (4) @(negedge axi_aclk);
    chk("cr_grants", 64'(glog.size()), 64'd1);
    chk("cr_req",    64'(mem_req),     64'd0);
    chk("cr_outs",   64'(max_outs),    64'd1);
    tx_space = 4'd4;
    repeat (2) @(negedge axi_aclk);
    chk("cr_grants2", 64'(glog.size()), 64'd2);
    chk("cr_addr2",   64'(glog[1].addr), 64'h3004);
    tx_space = 4'd8;
    do_abort();
    wait_idle("cr_idle");

    // Abort with a read outstanding and another request held without grant.
    glog.delete(); rlat = 10;
    send_cmd(32'h0000_4000, 1'b1);
    n = 0;
    do begin
      @(negedge axi_aclk);
      n++;
    end while (outs_cnt != 1 && n < 20);
    chk("dr_outs1", 64'(outs_cnt), 64'd1);
    gnt_en = 1'b0;
    @(negedge axi_aclk);
    chk("dr_req_pend", 64'(mem_req), 64'd1);
    do_abort();
    tx_base = tx_log.size();
    repeat (3) @(negedge axi_aclk);
    chk("dr_busy",     64'(busy),          64'd1);
    chk("dr_addr_rdy", 64'(rx_addr_ready), 64'd0);
    chk("dr_req_held", 64'(mem_req),       64'd1);
    chk("dr_req_addr", 64'(mem_addr),      64'h4004);
    gnt_en = 1'b1;
    wait_idle("dr_idle");
    chk("dr_dropped",   64'(tx_log.size() - tx_base), 64'd0);
    chk("dr_grants",    64'(glog.size()),             64'd2);
    chk("dr_addr_rdy2", 64'(rx_addr_ready),           64'd1);

    // Address wrap at the top of the space.
    glog.delete(); rlat = 2;
    send_cmd(32'hFFFF_FFF8, 1'b1);
    repeat (12) @(negedge axi_aclk);
    chk("wrap0", 64'(glog[0].addr), 64'hFFFF_FFF8);
    chk("wrap1", 64'(glog[1].addr), 64'hFFFF_FFFC);
    chk("wrap2", 64'(glog[2].addr), 64'h0000_0000);
    do_abort();
    wait_idle("wrap_idle");

    // Bus error on the second read response.
    tx_base = tx_log.size(); err_idx = resp_idx + 2;
    send_cmd(32'h0000_5000, 1'b1);
    n = 0;
    do begin
      @(negedge axi_aclk);
      n++;
    end while (tx_log.size() < tx_base + 1 && n < 30);
    chk("err_before", 64'(err), 64'd0);
    n = 0;
    do begin
      @(negedge axi_aclk);
      n++;
    end while (tx_log.size() < tx_base + 3 && n < 30);
    chk("err_set",  64'(err), 64'd1);
    chk("err_data", 64'(tx_log[tx_base + 1]), 64'h5A5A_5004);
    err_idx = -1;
    do_abort();
    wait_idle("err_idle");
    chk("err_sticky", 64'(err), 64'd1);

    // Reset in the middle of a read burst.
    send_cmd(32'h0000_6000, 1'b1);
    repeat (5) @(negedge axi_aclk);
    axi_aresetn = 1'b0;
    #1;
    chk("mr_req",      64'(mem_req),       64'd0);
    chk("mr_busy",     64'(busy),          64'd0);
    chk("mr_err",      64'(err),           64'd0);
    chk("mr_addr_rdy", 64'(rx_addr_ready), 64'd1);
    chk("mr_addr",     64'(mem_addr),      64'd0);
    chk("mr_wdata",    64'(mem_wdata),     64'd0);
    chk("mr_we",       64'(mem_we),        64'd0);
    chk("mr_be",       64'(mem_be),        64'hF);
    @(negedge axi_aclk);
    chk("mr_txv", 64'(tx_data_valid), 64'd0);
    chk("mr_txd", 64'(tx_data),       64'd0);
    axi_aresetn = 1'b1;
    repeat (3) @(negedge axi_aclk);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_err",  64'(err),  64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
